fwuart_rx: RTL and testbench
============================

# fwuart_rx

UART receiver for the fwuart block; the counterpart of the fwuart transmitter. It oversamples the serial `rx` line using the shared `clock_x16` enable and recovers 8N1 frames (start bit, 8 data bits LSB-first, 1 stop bit). Each good byte is presented on a ready/valid initiator port in the data-interface clock domain. The receiver flags framing errors and overruns with single-cycle pulses.

## Interface
- Parameters: none (8 data bits, 16x oversampling, 1 stop bit fixed).
- `clock`  in  1  data-interface clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clock_x16`  in  1  single-cycle enable at 16x the baud rate.
- `rx`  in  1  serial line; idles high.
- `i_dat`  out  8  received byte.
- `i_valid`  out  1  `i_dat` holds an unconsumed byte.
- `i_ready`  in  1  downstream accepts the byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte was dropped because the holding register was full.

## Operation
- Reset values:
  - Outputs: `i_valid`=0, `i_dat`=0x00, `frame_err`=0, `overrun`=0.
  - Internal: state IDLE, 4-bit tick counter `cnt`=0, bit counter=0, shift register=0x00.
  - Synchronizer flops reset to 1.
- `cnt` advances only on cycles with `clock_x16`=1. It wraps 15->0 and is cleared on every state transition.
- State machine (`rxs` is the synchronized or raw `rx`; every transition below requires `clock_x16`=1):
  - IDLE: `rxs`=0 -> START.
  - START: at `cnt`==7 (middle of the start bit), if `rxs`=1 the start was false -> IDLE; otherwise -> DATA with bit counter=0.
  - DATA: at `cnt`==15, `shreg <= {rxs, shreg[7:1]}` and the bit counter increments. At the 8th sample (bit counter==7) -> STOP.
  - STOP: at `cnt`==15, sample `rxs`.
    - `rxs`=1: deliver the byte, then -> IDLE.
    - `rxs`=0: pulse `frame_err`, discard the byte, -> BREAK.
  - BREAK: stay until `rxs`=1 is seen on a tick, then -> IDLE. This prevents a held-low line from being read as back-to-back start bits.
- Delivery:
  - If the holding register is empty, or `i_valid && i_ready` in the same cycle: load `i_dat`, hold `i_valid`=1.
  - Otherwise: pulse `overrun`, keep the old byte, drop the new one.
- Handshake:
  - `i_dat` is stable while `i_valid`=1.
  - The transfer happens on a cycle with `i_valid && i_ready`.
  - `i_valid` clears the next cycle unless a new byte loads in the same cycle.
- `i_valid` does not depend combinationally on `i_ready`.
- Reset asserted mid-frame aborts the frame immediately. Any held byte is lost and the receiver returns to IDLE.

## Timing
- Every sample point is mid-bit: 8 ticks after the falling edge, then every 16 ticks.
- Byte output latency: `i_valid` rises on the clock edge following the stop-bit sample tick.
  - The stop-bit sample tick falls 9.5 bit-times after the falling edge of the start bit.
  - With the synchronizer compiled in, add 2 `clock` cycles.
- `frame_err` and `overrun` are registered and high for exactly one `clock` cycle.
- Throughput: continuous back-to-back frames with no idle gap are supported. The next start bit can be detected on the tick after the stop sample.
- `clock_x16` held low freezes the state machine and the counters. The output handshake still operates.

## Configuration
- `FWUART_RX_SYNC_EN` defined: `rx` passes through a 2-flop synchronizer (reset value 1) before use. This is required when `rx` is asynchronous to `clock`.
- Undefined: `rx` is used directly. This is only for the case where `rx` is already synchronous to `clock` (e.g. internal loopback from the transmitter). Latency drops by 2 cycles.

## Structure
- Shared package `fwuart_pkg`:
  - state encoding localparams: IDLE, START, DATA, STOP, BREAK;
  - `FWUART_OVERSAMPLE`=16;
  - `FWUART_MID_TICK`=7;
  - `FWUART_DATA_BITS`=8.
- Port declaration uses the team's ready/valid initiator-port macro with prefix `i_` and width 8.
- One sub-module, `fwuart_sync`: a 2-flop synchronizer with a reset-value parameter. It is instantiated only under `FWUART_RX_SYNC_EN`.

## Test plan
- Byte 0xA5 framed 8N1, `i_ready`=1 -> `i_dat`=0xA5 and `i_valid` high for one cycle; no error pulses.
- Bytes 0x00 then 0xFF sent back-to-back with no idle gap -> two deliveries in order, 0x00 then 0xFF.
- A 4-tick low glitch on idle `rx` -> no delivery and no error; the next frame 0x3C is received correctly.
- Frame 0x55 with the stop bit driven low, followed by a 40-tick low hold -> one `frame_err` pulse, no `i_valid`. After the line returns high, frame 0x81 is received correctly.
- `i_ready`=0 while 0x11 then 0x22 arrive -> `i_dat` stays 0x11 and one `overrun` pulse is seen. Raising `i_ready` on the same cycle as a stop sample loads the new byte with no overrun.
- `reset_n` asserted during data bit 4 -> all outputs return to reset values at once. After release, frame 0x7E is received correctly.

Source files
------------

// File: rtl/fwuart_pkg.sv
// Shared definitions for the fwuart receiver: state encoding and fixed frame geometry.
package fwuart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } fwuart_state_e;

  localparam int unsigned FWUART_OVERSAMPLE = 16;
  localparam int unsigned FWUART_MID_TICK   = 7;
  localparam int unsigned FWUART_DATA_BITS  = 8;

endpackage

// File: rtl/fwuart_sync.sv
// Two-flop synchronizer with a configurable reset value.
module fwuart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fwuart_rx.sv
// fwuart 8N1 receiver, 16x oversampled, ready/valid byte output with error pulses.
// Define FWUART_RX_SYNC_EN to put rx through a 2-flop synchronizer (adds 2 cycles of latency).
module fwuart_rx
  import fwuart_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_x16,
  input  logic       rx,
  output logic [7:0] i_dat,
  output logic       i_valid,
  input  logic       i_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(FWUART_OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(FWUART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(FWUART_MID_TICK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FWUART_OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FWUART_DATA_BITS - 1);

  fwuart_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shreg;
  logic             rxs;
  logic             shift_en;
  logic             deliver;
  logic             ferr_set;

`ifdef FWUART_RX_SYNC_EN
  fwuart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rxs)
  );
`else
  assign rxs = rx;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clock_x16) begin
      case (state)
        IDLE:    if (!rxs) state_nxt = START;
        START:   if (cnt == CNT_MID) state_nxt = rxs ? IDLE : DATA;
        DATA:    if (cnt == CNT_LAST && bit_cnt == BIT_LAST) state_nxt = STOP;
        STOP:    if (cnt == CNT_LAST) state_nxt = rxs ? IDLE : BREAK;
        BREAK:   if (rxs) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    deliver  = 1'b0;
    ferr_set = 1'b0;
    if (clock_x16 && cnt == CNT_LAST) begin
      case (state)
        DATA:    shift_en = 1'b1;
        STOP: begin
          deliver  = rxs;
          ferr_set = !rxs;
        end
        default: ;
      endcase
    end
  end

  // cnt restarts on every state change so each state measures from its own entry tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clock_x16) begin
      cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == START)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)
        shreg <= {rxs, shreg[7:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_dat     <= '0;
      i_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= deliver && i_valid && !i_ready;
      if (deliver && (!i_valid || i_ready)) begin
        i_dat   <= shreg;
        i_valid <= 1'b1;
      end else if (i_ready) begin
        i_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fwuart_rx.sv
// Self-checking bench for fwuart_rx: tick-indexed line model plus directed and random frames.
module tb_fwuart_rx;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       clock_x16 = 1'b0;
  logic       rx        = 1'b1;
  logic       i_ready   = 1'b0;
  logic [7:0] i_dat;
  logic       i_valid;
  logic       frame_err;
  logic       overrun;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  fwuart_rx dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clock_x16 (clock_x16),
    .rx        (rx),
    .i_dat     (i_dat),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One tick every third clock, suppressed while tick_en is low.
  logic tick_en = 1'b1;
  initial begin
    int unsigned ph;
    ph = 0;
    forever begin
      @(negedge clock);
      clock_x16 = tick_en && (ph == 2);
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  // Reference model: line level recorded per tick; a frame is judged by fixed offsets
  // from the detection tick d (start check d+8, data bit i at d+24+16i, stop at d+152).
  logic        m_s1 = 1'b1, m_s2 = 1'b1;
  logic        hist [256];
  int unsigned m_t = 0, m_d = 0;
  int          m_mode = 0;  // 0 hunting, 1 in frame, 2 waiting for line high
  logic        m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0]  m_dat = '0;

  always @(posedge clock) begin
    logic       rxs_now, dlv, fe;
    logic [7:0] b;
    if (!reset_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0;
      m_valid = 1'b0; m_dat = '0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      dlv = 1'b0; fe = 1'b0; b = '0;
`ifdef FWUART_RX_SYNC_EN
      rxs_now = m_s2;
`else
      rxs_now = rx;
`endif
      if (clock_x16) begin
        hist[m_t % 256] = rxs_now;
        if (m_mode == 0) begin
          if (!rxs_now) begin m_d = m_t; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (m_t - m_d == 8 && rxs_now) m_mode = 0;
          else if (m_t - m_d == 152) begin
            for (int i = 0; i < 8; i++) b[i] = hist[(m_d + 24 + 16 * i) % 256];
            if (rxs_now) begin dlv = 1'b1; m_mode = 0; end
            else begin fe = 1'b1; m_mode = 2; end
          end
        end else if (rxs_now) begin
          m_mode = 0;
        end
        m_t++;
      end
      m_ferr = fe;
      m_ovr  = dlv && m_valid && !i_ready;
      if (dlv && (!m_valid || i_ready)) begin m_valid = 1'b1; m_dat = b; end
      else if (m_valid && i_ready) m_valid = 1'b0;
      m_s2 = m_s1;
      m_s1 = rx;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        check("cyc_valid", i_valid, m_valid);
        check("cyc_dat", i_dat, m_dat);
        check("cyc_frame_err", frame_err, m_ferr);
        check("cyc_overrun", overrun, m_ovr);
      end
    end
  end

  logic [7:0]  acc_log [$];
  int unsigned n_ferr = 0, n_ovr = 0, n_vcyc = 0;

  always @(posedge clock) begin
    if (reset_n) begin
      if (i_valid && i_ready) acc_log.push_back(i_dat);
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (i_valid)   n_vcyc++;
    end
  end

  function automatic logic [31:0] log_at(input int unsigned i);
    return (i < acc_log.size()) ? {24'h0, acc_log[i]} : 32'hDEAD;
  endfunction

  task automatic clear_stats();
    acc_log.delete();
    n_ferr = 0; n_ovr = 0; n_vcyc = 0;
  endtask

  task automatic wait_tick();
    int unsigned k;
    k = 0;
    do begin
      @(posedge clock);
      k++;
    end while (!clock_x16 && k < 200);
    if (k >= 200) check("tick_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic wait_ticks(input int unsigned n);
    repeat (n) wait_tick();
  endtask

  task automatic send_bits(input logic [9:0] bits, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      rx = bits[i];
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits({stop, b, 1'b0}, 10);
  endtask

  logic rand_ready = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (rand_ready) i_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    int unsigned k;
    logic        found;
    logic [7:0]  b;
    logic        bad;

    repeat (3) @(negedge clock);
    check("rst_valid", i_valid, 0);
    check("rst_dat", i_dat, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    #2 reset_n = 1'b1;
    i_ready = 1'b1;
    wait_ticks(20);

    clear_stats();
    send_frame(8'hA5, 1'b1);
    wait_ticks(20);
    check("a5_count", acc_log.size(), 1);
    check("a5_dat", log_at(0), 32'hA5);
    check("a5_valid_cycles", n_vcyc, 1);
    check("a5_ferr", n_ferr, 0);
    check("a5_ovr", n_ovr, 0);

    clear_stats();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(20);
    check("b2b_count", acc_log.size(), 2);
    check("b2b_first", log_at(0), 32'h00);
    check("b2b_second", log_at(1), 32'hFF);

    clear_stats();
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_none", acc_log.size(), 0);
    send_frame(8'h3C, 1'b1);
    wait_ticks(20);
    check("glitch_count", acc_log.size(), 1);
    check("glitch_dat", log_at(0), 32'h3C);
    check("glitch_ferr", n_ferr, 0);

    clear_stats();
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    wait_ticks(40);
    check("brk_no_valid", n_vcyc, 0);
    rx = 1'b1;
    wait_ticks(20);
    send_frame(8'h81, 1'b1);
    wait_ticks(20);
    check("brk_ferr", n_ferr, 1);
    check("brk_count", acc_log.size(), 1);
    check("brk_dat", log_at(0), 32'h81);

    clear_stats();
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_ticks(20);
    check("ovr_dat_held", i_dat, 8'h11);
    check("ovr_valid_held", i_valid, 1);
    check("ovr_pulses", n_ovr, 1);
    found = 1'b0;
    fork
      send_frame(8'h33, 1'b1);
      begin
        k = 0;
        while (!found && k < 5000) begin
          @(negedge clock);
          #1;
          k++;
          if (clock_x16 && m_mode == 1 && m_t - m_d == 152) found = 1'b1;
        end
        i_ready = 1'b1;
      end
    join
    check("ovr_stop_align", found, 1);
    wait_ticks(20);
    check("ovr_pulses_after", n_ovr, 1);
    check("ovr_log_count", acc_log.size(), 2);
    check("ovr_log0", log_at(0), 32'h11);
    check("ovr_log1", log_at(1), 32'h33);

    i_ready = 1'b0;
    send_frame(8'h44, 1'b1);
    wait_ticks(20);
    check("pre_rst_held", i_valid, 1);
    send_bits({1'b1, 8'h99, 1'b0}, 5);
    rx = 1'b1;
    wait_ticks(8);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", i_valid, 0);
    check("mid_rst_dat", i_dat, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    rx = 1'b1;
    i_ready = 1'b1;
    wait_ticks(20);
    clear_stats();
    send_frame(8'h7E, 1'b1);
    wait_ticks(20);
    check("post_rst_count", acc_log.size(), 1);
    check("post_rst_dat", log_at(0), 32'h7E);

    clear_stats();
    fork
      send_frame(8'hC3, 1'b1);
      begin
        wait_ticks(60);
        tick_en = 1'b0;
        repeat (50) @(negedge clock);
        tick_en = 1'b1;
      end
    join
    wait_ticks(20);
    check("freeze_count", acc_log.size(), 1);
    check("freeze_dat", log_at(0), 32'hC3);

    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b   = 8'($urandom);
      bad = ($urandom % 8) == 0;
      send_frame(b, !bad);
      if (bad) begin
        rx = 1'b0;
        wait_ticks($urandom_range(0, 40));
        rx = 1'b1;
      end
      if (($urandom % 3) != 0) wait_ticks($urandom_range(0, 20));
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    rx = 1'b1;
    wait_ticks(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
